uart_word_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_byte.sv | 108 ++++++++++
 rtl/uart_word_tx.sv | 100 ++++++++++
 tb/tb_uart_word_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per byte).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  // Word-level sequencing: high byte, then low byte, then a one-cycle completion.
  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO,
    DONE
  } word_state_t;

  // Byte-level framing.
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PARITY,
    B_STOP
  } byte_state_t;
`else
  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as a UART frame: start, 8 data bits LSB first,
// optional even parity (UART_TX_PARITY_EN), stop. A start strobe seen during
// the last stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_start,
  output logic       uart_tx,
  output logic       byte_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_FRAME_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST_DATA = IDX_W'(UART_DATA_BITS);

  byte_state_t       state_q;
  byte_state_t       state_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              tx_d;
  logic              bit_end;
  logic              load;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign byte_done = (state_q == B_STOP) && bit_end;
  // A new byte is taken when idle or exactly at the end of the current stop bit.
  assign load      = byte_start && ((state_q == B_IDLE) || byte_done);

  // Byte FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= B_IDLE;
    else        state_q <= state_d;
  end

  // Byte FSM next-state: each bit lasts CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      B_IDLE:   if (load) state_d = B_START;
      B_START:  if (bit_end) state_d = B_DATA;
      B_DATA: begin
        if (bit_end && (bit_idx == IDX_LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
          state_d = B_PARITY;
`else
          state_d = B_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      B_PARITY: if (bit_end) state_d = B_STOP;
`endif
      B_STOP:   if (bit_end) state_d = load ? B_START : B_IDLE;
      default:  state_d = B_IDLE;
    endcase
  end

  // Output decode: next shift contents and the line level for the coming cycle.
  always_comb begin
    shift_d = shift_q;
    tx_d    = 1'b1;
    if (load) shift_d = byte_data;
    else if ((state_q == B_DATA) && bit_end) shift_d = {1'b0, shift_q[7:1]};
    case (state_d)
      B_START:  tx_d = 1'b0;
      B_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      B_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Baud counter, bit index, shift register and the registered line driver.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      uart_tx <= tx_d;
`ifdef UART_TX_PARITY_EN
      if (load) parity_q <= ^byte_data;
`endif
      if ((state_q == B_IDLE) || (state_d == B_IDLE) || bit_end) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + 1'b1;
      if (load || (state_d == B_IDLE)) bit_idx <= '0;
      else if (bit_end) bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// 16-bit word UART transmitter: two back-to-back frames, high byte first,
// plus a wrapping count of completed words. Frame format depends on
// UART_TX_PARITY_EN (defined: 8E1, undefined: 8N1).
//
// Handshake: a word is accepted on a rising edge with tx_valid && tx_ready.
// tx_ready is high only while idle; tx_valid at other times is ignored, not
// queued. tx_data is captured on acceptance and may change afterwards.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int WORD_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [15:0]       word_count
);

  if (WORD_W != 2 * UART_DATA_BITS) begin : g_bad_word_w
    $error("uart_word_tx: WORD_W must be 16");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
  end

  word_state_t state_q;
  word_state_t state_d;
  logic [7:0]  word_lo_q;
  logic [7:0]  byte_data;
  logic        accept;
  logic        byte_start;
  logic        byte_done;
  logic        ready_d;
  logic        done_d;

  assign accept     = tx_valid && (state_q == IDLE);
  // The high byte launches straight from the input so its start bit begins at
  // the acceptance edge; the low byte chains off the high byte's last cycle.
  assign byte_start = accept || ((state_q == SEND_HI) && byte_done);
  assign byte_data  = accept ? tx_data[15:8] : word_lo_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_start(byte_start),
    .uart_tx   (uart_tx),
    .byte_done (byte_done)
  );

  // Word FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Word FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND_HI;
      SEND_HI: if (byte_done) state_d = SEND_LO;
      SEND_LO: if (byte_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the status flops track the FSM.
  always_comb begin
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // Registered status outputs, low-byte latch and completed-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      word_count <= '0;
      word_lo_q  <= '0;
    end else begin
      tx_ready <= ready_d;
      tx_busy  <= ~ready_d;
      tx_done  <= done_d;
      if (done_d) word_count <= word_count + 16'd1;
      if (accept) word_lo_q <= tx_data[7:0];
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: frame-level reference model checked every cycle,
// plus directed literal expectations for the documented timing points.
module tb_uart_word_tx;

  localparam int C = 8;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
  localparam int DONE_CYC = 177;
`else
  localparam int F = 10;
  localparam int DONE_CYC = 161;
`endif
  localparam int WORD_CYC = 2 * F * C;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        uart_tx;
  logic        tx_busy;
  logic        tx_done;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  uart_word_tx #(
    .CLKS_PER_BIT(C),
    .WORD_W      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .word_count(word_count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_pos: -1 when idle, otherwise cycles elapsed since the acceptance edge
  // (0 .. WORD_CYC-1 on the line, WORD_CYC is the completion cycle).
  int          m_pos = -1;
  logic [15:0] m_count = 16'h0000;
  logic        m_bits[0:21];
  logic        chk_en = 1'b0;
  logic        exp_tx;

  function automatic void load_frames(input logic [15:0] w);
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? w[15:8] : w[7:0];
      m_bits[i*F] = 1'b0;
      for (int j = 0; j < 8; j++) m_bits[i*F+1+j] = b[j];
      if (F == 11) m_bits[i*F+9] = ^b;
      m_bits[i*F+F-1] = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos   = -1;
      m_count = 16'h0000;
      chk_en  = 1'b1;
    end else if (m_pos < 0) begin
      if (tx_valid) begin
        load_frames(tx_data);
        m_pos = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == WORD_CYC) m_count = m_count + 16'd1;
      else if (m_pos == WORD_CYC + 1) m_pos = -1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_tx = (m_pos >= 0 && m_pos < WORD_CYC) ? m_bits[m_pos / C] : 1'b1;
      check("model uart_tx", uart_tx, exp_tx);
      check("model tx_ready", tx_ready, (m_pos < 0));
      check("model tx_busy", tx_busy, (m_pos >= 0));
      check("model tx_done", tx_done, (m_pos == WORD_CYC));
      check("model word_count", word_count, m_count);
    end
  end

  // ---------------- capture buffers ----------------
  logic        cap_tx[0:400];
  logic        cap_done[0:400];
  logic        cap_rdy[0:400];
  logic [15:0] cap_cnt[0:400];

  task automatic capture(input int k);
    cap_tx[k]   = uart_tx;
    cap_done[k] = tx_done;
    cap_rdy[k]  = tx_ready;
    cap_cnt[k]  = word_count;
  endtask

  // Driver: one word with a single-cycle valid, then wait for completion.
  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    @(posedge clk);
    for (int k = 1; k <= WORD_CYC + 2; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      capture(k);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] w;
  logic [21:0] lit;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle uart_tx", uart_tx, 1);
    check("idle tx_ready", tx_ready, 1);
    check("idle tx_busy", tx_busy, 0);
    check("idle tx_done", tx_done, 0);
    check("idle word_count", word_count, 16'h0000);

    // Single word with hand-computed bit sequence; a stray valid mid-frame.
`ifdef UART_TX_PARITY_EN
    w   = 16'h0301;
    lit = 22'b11000000010_10000000110;
`else
    w   = 16'hA55A;
    lit = 22'b00_1010110100_1101001010;
`endif
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = w;
    @(posedge clk);
    for (int k = 1; k <= WORD_CYC + 2; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
      if (k == 30) begin tx_valid = 1'b1; tx_data = 16'h7777; end
      if (k == 31) tx_valid = 1'b0;
      capture(k);
    end
    for (int b = 0; b < 2 * F; b++) begin
      check($sformatf("literal bit %0d first", b), cap_tx[b*C+1], lit[b]);
      check($sformatf("literal bit %0d last", b), cap_tx[b*C+C], lit[b]);
    end
    check("literal done cycle", cap_done[DONE_CYC], 1);
    check("literal no early done", cap_done[DONE_CYC-1], 0);
    check("literal count after word", cap_cnt[DONE_CYC], 16'h0001);
    check("literal ready low in done", cap_rdy[DONE_CYC], 0);
    check("literal ready after done", cap_rdy[DONE_CYC+1], 1);

    // Back-to-back with valid held and tx_data disturbed during the first frame.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 16'h0001;
    @(posedge clk);
    for (int k = 1; k <= WORD_CYC + 4; k++) begin
      @(negedge clk);
      capture(k);
      if (k == 5) tx_data = 16'hFFFF;
      if (k == 100) tx_data = 16'h0002;
      if (k == WORD_CYC + 3) tx_valid = 1'b0;
    end
    check("b2b first done", cap_done[WORD_CYC+1], 1);
    check("b2b ready window", cap_rdy[WORD_CYC+2], 1);
    check("b2b line idle in gap", cap_tx[WORD_CYC+2], 1);
    check("b2b second start bit", cap_tx[WORD_CYC+3], 0);
    check("b2b second accepted", cap_rdy[WORD_CYC+3], 0);
    check("b2b first low-byte d0", cap_tx[F*C+C+1], 1);
    repeat (WORD_CYC + 2) @(negedge clk);
    check("b2b count", word_count, 16'h0003);
    check("b2b idle ready", tx_ready, 1);

    // Reset in the middle of a word.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 16'h1234;
    @(posedge clk);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) tx_valid = 1'b0;
    end
    check("midreset line before", uart_tx, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset uart_tx", uart_tx, 1);
    check("midreset tx_done", tx_done, 0);
    check("midreset word_count", word_count, 16'h0000);
    check("midreset tx_ready", tx_ready, 1);
    check("midreset tx_busy", tx_busy, 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post reset count", word_count, 16'h0000);

    // A few more patterns through the model.
    send_word(16'h0000);
    send_word(16'hFFFF);
    send_word(16'h8C31);
    check("pattern count", cap_cnt[DONE_CYC], 16'h0003);

    // Counter wrap from 0xFFFF.
    @(posedge clk);
    #2;
    force dut.word_count = 16'hFFFF;
    m_count = 16'hFFFF;
    #1;
    release dut.word_count;
    @(negedge clk);
    check("wrap preload", word_count, 16'hFFFF);
    send_word(16'h8001);
    check("wrap done", cap_done[DONE_CYC], 1);
    check("wrap count", cap_cnt[DONE_CYC], 16'h0000);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
